// File: rtl/regfile_32x64_pkg.sv
// Shared definitions for the 32 x DATA_WIDTH register file: default sizing,
// the register-index type used by every pipeline stage, and the 5-to-32
// write-enable decoder.
package regfile_32x64_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ZERO_REG_DEF   = 31;
  localparam int NUM_REGS       = 32;
  localparam int IDX_W          = 5;

  // Register index as carried through decode/execute/writeback.
  typedef logic [IDX_W-1:0] reg_idx_t;

  // One-hot write-enable decode: line i is high iff en=1 and idx=i.
  function automatic logic [NUM_REGS-1:0] decode_we(input logic en, input reg_idx_t idx);
    logic [NUM_REGS-1:0] lines;
    lines = '0;
    if (en) lines[idx] = 1'b1;
    return lines;
  endfunction

endpackage

// File: rtl/regfile_32x64_reg_word.sv
// One storage word: DATA_WIDTH-bit enabled D-register with asynchronous
// active-low clear.
module reg_word #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  // Load on enable, clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_32x64.sv
// 32-entry register file with a hardwired-zero register, two combinational
// read ports and writeback-to-decode forwarding on each read port.
module regfile_32x64
  import regfile_32x64_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam reg_idx_t ZR = reg_idx_t'(ZERO_REG);

  logic [NUM_REGS-1:0]                 w_we;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_q;
  logic                                w_unused_zero_we;
  logic                                w_byp1;
  logic                                w_byp2;

  // Decoded write lines; the zero-register line is intentionally dropped.
  assign w_we             = decode_we(write_en, reg_idx_t'(write_reg));
  assign w_unused_zero_we = w_we[ZR];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == ZERO_REG) begin : g_zero
        // XZR has no storage; it always reads as zero.
        assign w_q[gi] = '0;
      end else begin : g_word
        reg_word #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
          .clk   (clk),
          .rst_n (rst_n),
          .i_en  (w_we[gi]),
          .i_d   (write_data),
          .o_q   (w_q[gi])
        );
      end
    end
  endgenerate

  // Forwarding applies only to a live, non-zero destination outside reset.
  assign w_byp1 = rst_n && write_en && (write_reg == read_reg1) && (reg_idx_t'(write_reg) != ZR);
  assign w_byp2 = rst_n && write_en && (write_reg == read_reg2) && (reg_idx_t'(write_reg) != ZR);

  // Read port 1: reset and XZR force zero, then bypass, then 32:1 mux.
  always_comb begin
    read_data1 = '0;
    if (!rst_n)                         read_data1 = '0;
    else if (reg_idx_t'(read_reg1) == ZR) read_data1 = '0;
    else if (w_byp1)                    read_data1 = write_data;
    else                                read_data1 = w_q[read_reg1];
  end

  // Read port 2: same selection, independent of port 1.
  always_comb begin
    read_data2 = '0;
    if (!rst_n)                         read_data2 = '0;
    else if (reg_idx_t'(read_reg2) == ZR) read_data2 = '0;
    else if (w_byp2)                    read_data2 = write_data;
    else                                read_data2 = w_q[read_reg2];
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Bench for regfile_32x64: a reference register array updated from the
// architectural write rules, checked every negedge, plus directed literals.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [63:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [32] = '{default: 64'd0};

  regfile_32x64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural state: reset clears everything, XZR never stores.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 64'd0;
    end else if (write_en && write_reg != 5'd31) begin
      mdl[write_reg] <= write_data;
    end
  end

  function automatic logic [63:0] expect_rd(input logic [4:0] idx);
    if (!rst_n)                              return 64'd0;
    if (idx == 5'd31)                        return 64'd0;
    if (write_en && write_reg == idx)        return write_data;
    return mdl[idx];
  endfunction

  // Continuous comparison on the inactive edge.
  always @(negedge clk) begin
    check("cmp_rd1", read_data1, expect_rd(read_reg1));
    check("cmp_rd2", read_data2, expect_rd(read_reg2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    write_en = 1'b1; write_reg = r; write_data = d;
    step();
    write_en = 1'b0;
  endtask

  typedef struct { logic [4:0] r; logic [63:0] d; } vec_t;
  vec_t vecs [6] = '{
    '{5'd0,  64'hDEAD_BEEF_0000_0001},
    '{5'd1,  64'h8000_0000_0000_0000},
    '{5'd30, 64'hFFFF_FFFF_FFFF_FFFF},
    '{5'd15, 64'h0000_0000_0000_0001},
    '{5'd16, 64'h5A5A_A5A5_5A5A_A5A5},
    '{5'd0,  64'h0000_0000_0000_0000}
  };

  initial begin
    // Reset held: every index reads 0 on both ports, even with a write pending.
    write_en = 1'b1; write_reg = 5'd2; write_data = 64'h1234;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      check("rst_rd1", read_data1, 64'd0);
      check("rst_rd2", read_data2, 64'd0);
    end
    write_en = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // First edge after release takes a write; X5 readable next cycle.
    wr(5'd5, 64'h0123_4567_89AB_CDEF);
    read_reg1 = 5'd5; read_reg2 = 5'd4; #1;
    check("x5_store", read_data1, 64'h0123_4567_89AB_CDEF);
    check("x4_zero",  read_data2, 64'd0);
    read_reg2 = 5'd6; #1;
    check("x6_zero",  read_data2, 64'd0);
    step();

    // Writes to XZR vanish, including on the bypass path.
    write_en = 1'b1; write_reg = 5'd31; write_data = '1;
    read_reg1 = 5'd31; read_reg2 = 5'd31; #1;
    check("xzr_same1", read_data1, 64'd0);
    check("xzr_same2", read_data2, 64'd0);
    step();
    write_en = 1'b0; #1;
    check("xzr_next1", read_data1, 64'd0);
    check("xzr_next2", read_data2, 64'd0);

    // Both ports bypass a write to the register they read.
    wr(5'd7, 64'h11);
    write_en = 1'b1; write_reg = 5'd7; write_data = 64'h22;
    read_reg1 = 5'd7; read_reg2 = 5'd7; #1;
    check("byp1_pre", read_data1, 64'h22);
    check("byp2_pre", read_data2, 64'h22);
    step();
    write_en = 1'b0; #1;
    check("byp1_post", read_data1, 64'h22);
    check("byp2_post", read_data2, 64'h22);

    // Mixed: port 1 bypasses, port 2 reads storage.
    write_en = 1'b1; write_reg = 5'd8; write_data = 64'h88;
    read_reg1 = 5'd8; read_reg2 = 5'd5; #1;
    check("mix_byp", read_data1, 64'h88);
    check("mix_sto", read_data2, 64'h0123_4567_89AB_CDEF);
    step();
    write_en = 1'b0;

    // Disabled write leaves X3 alone.
    wr(5'd3, 64'h33);
    write_en = 1'b0; write_reg = 5'd3; write_data = 64'hFF;
    read_reg1 = 5'd3; read_reg2 = 5'd8;
    step(); #1;
    check("we0_hold", read_data1, 64'h33);
    check("x8_store", read_data2, 64'h88);

    // Directed vector table, checked by the continuous comparison.
    foreach (vecs[k]) begin
      read_reg1 = vecs[k].r; read_reg2 = 5'd3;
      wr(vecs[k].r, vecs[k].d);
    end
    read_reg1 = 5'd30; #1;
    check("x30_store", read_data1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Mid-cycle async reset clears immediately and blocks writes.
    wr(5'd9, 64'hAA);
    read_reg1 = 5'd9; read_reg2 = 5'd9; #1;
    check("x9_pre", read_data1, 64'hAA);
    #1 rst_n = 1'b0; #1;
    check("x9_async", read_data1, 64'd0);
    write_en = 1'b1; write_reg = 5'd9; write_data = 64'h55; #1;
    check("rst_nobyp", read_data2, 64'd0);
    step();
    write_en = 1'b0;
    step();
    rst_n = 1'b1; #1;
    check("x9_after", read_data1, 64'd0);
    read_reg2 = 5'd30; #1;
    check("x30_clr", read_data2, 64'd0);

    // First write after release lands on the first edge.
    write_en = 1'b1; write_reg = 5'd10; write_data = 64'hCAFE;
    step();
    write_en = 1'b0; read_reg1 = 5'd10; #1;
    check("post_rst_wr", read_data1, 64'hCAFE);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 Parameter: DATA_WIDTH, 64, width of each register and of all data ports.
REQ-002 Parameter: ZERO_REG, 31, index of the hardwired-zero register (XZR).
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: write_en  input  1  writeback request (RegWrite) for the current cycle.
REQ-007 Port: write_reg  input  5  destination register index.
REQ-008 Port: write_data  input  DATA_WIDTH  value to store.
REQ-009 Port: read_reg1  input  5  read port 1 index (Rn).
REQ-010 Port: read_reg2  input  5  read port 2 index (Rm/Rt).
REQ-011 Port: read_data1  output  DATA_WIDTH  read port 1 data.
REQ-012 Port: read_data2  output  DATA_WIDTH  read port 2 data.

Function
REQ-013 Storage SHALL be 32 registers of DATA_WIDTH bits; the register at ZERO_REG SHALL have no storage.
REQ-014 Write-enable decode SHALL be one-hot over 32 lines: line i asserted iff write_en=1 and write_reg=i.
REQ-015 On a rising clk edge with line i asserted and i != ZERO_REG, register i SHALL load write_data; all other registers SHALL hold.
REQ-016 A write to ZERO_REG SHALL be discarded with no state change.
REQ-017 With write_en=0, no register SHALL change regardless of write_reg/write_data.
REQ-018 Reads SHALL be combinational (zero-cycle latency) from the addressed register.
REQ-019 A read of ZERO_REG on either port SHALL return 0 at all times, including during a same-cycle write to ZERO_REG.
REQ-020 Bypass: if write_en=1, write_reg=read_regN, and write_reg != ZERO_REG, read_dataN SHALL equal write_data in that same cycle (writeback-to-decode forwarding).
REQ-021 Both read ports SHALL operate independently; both may address the same register, and both SHALL bypass simultaneously when both match write_reg.
REQ-022 Written value SHALL be visible through storage (no bypass) from the cycle after the write edge onward.

Reset
REQ-023 While rst_n=0, all 31 stored registers SHALL be 0 immediately (no clock required), and both read ports SHALL return 0 for any index.
REQ-024 Reset SHALL override writes: a write_en asserted at an edge while rst_n=0 SHALL have no effect.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk upstream; the first write SHALL take effect on the first rising edge after rst_n=1.
REQ-026 Bypass SHALL be suppressed while rst_n=0 (read data is 0).

Structure
REQ-027 A shared package SHALL hold DATA_WIDTH default, ZERO_REG default, and a 5-bit register-index typedef used by all pipeline stages.
REQ-028 One storage sub-module, reg_word (DATA_WIDTH-bit enabled D-register with async active-low reset), SHALL be instantiated 31 times.
REQ-029 Write-line decode SHALL reuse the existing 5-to-32 write-enable decoder; read selection SHALL be a 32:1 mux per port.

Verification
REQ-030 Reset then read all 32 indices on both ports -> every read returns 0.
REQ-031 Write 0x0123_4567_89AB_CDEF to X5, next cycle read_reg1=5 -> read_data1=0x0123_4567_89AB_CDEF; X4 and X6 still 0.
REQ-032 write_en=1, write_reg=31, write_data=all-ones; read_reg1=read_reg2=31 same and next cycle -> both read 0.
REQ-033 X7=0x11 stored; same cycle write X7=0x22 with read_reg1=read_reg2=7 -> both ports read 0x22 before the edge and after.
REQ-034 write_en=0, write_reg=3, write_data=0xFF at an edge -> X3 remains previous value.
REQ-035 Write X9=0xAA, then assert rst_n=0 mid-cycle between edges -> read of X9 drops to 0 immediately; write at an edge during reset leaves X9=0 after release.
